// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes one RV32 ALU instruction at a time, drives the external
// ALU from registers, and hands back the captured result over a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    output logic [6:0]       alu_control,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    input  logic [31:0]      alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             out_err,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;

    state_t           r_state;
    logic [3:0]       r_alu_op;
    logic [31:0]      r_alu_in1;
    logic [31:0]      r_alu_in2;
    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic [4:0]       r_out_rd;
    logic             r_out_wen;
    logic             r_out_err;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    logic        w_legal;
    logic [3:0]  w_op;
    logic [31:0] w_in2;
    logic        w_unused_rs_fields;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm    = {{20{in_instr[31]}}, in_instr[31:20]};

    // rs1 index field is resolved by the register-read stage, so only its operand value matters here
    assign w_unused_rs_fields = ^in_instr[19:15];

    always_comb begin
        w_legal = 1'b0;
        w_op    = OP_ADD;
        w_in2   = in_rs2;
        unique case (w_opcode)
            OPC_RTYPE: begin
                w_in2 = in_rs2;
                unique case (w_funct3)
                    3'b000: begin
                        if (w_funct7 == F7_BASE) begin
                            w_legal = 1'b1;
                            w_op    = OP_ADD;
                        end else if (w_funct7 == F7_ALT) begin
                            w_legal = 1'b1;
                            w_op    = OP_SUB;
                        end
                    end
                    3'b100: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = OP_XOR;
                    end
                    3'b110: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = OP_OR;
                    end
                    3'b111: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = OP_AND;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_ITYPE: begin
                w_in2 = w_imm;
                unique case (w_funct3)
                    3'b000: begin
                        w_legal = 1'b1;
                        w_op    = OP_ADD;
                    end
                    3'b100: begin
                        w_legal = 1'b1;
                        w_op    = OP_XOR;
                    end
                    3'b110: begin
                        w_legal = 1'b1;
                        w_op    = OP_OR;
                    end
                    3'b111: begin
                        w_legal = 1'b1;
                        w_op    = OP_AND;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal instructions skip ISSUE and leave the ALU operand registers untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_alu_op      <= OP_ADD;
            r_alu_in1     <= '0;
            r_alu_in2     <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_wen     <= 1'b0;
            r_out_err     <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_out_rd <= in_instr[11:7];
                        if (w_legal) begin
                            r_alu_op  <= w_op;
                            r_alu_in1 <= in_rs1;
                            r_alu_in2 <= w_in2;
                            r_state   <= ISSUE;
                        end else begin
                            r_out_result <= '0;
                            r_out_err    <= 1'b1;
                            r_out_wen    <= 1'b0;
                            r_out_valid  <= 1'b1;
                            if (r_illegal_cnt != '1) begin
                                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
                            end
                            r_state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    r_out_result <= alu_out;
                    r_out_err    <= 1'b0;
                    r_out_wen    <= (r_out_rd != 5'd0);
                    r_out_valid  <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign alu_control = {3'b000, r_alu_op};
    assign alu_in1     = r_alu_in1;
    assign alu_in2     = r_alu_in2;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_rd      = r_out_rd;
    assign out_wen     = r_out_wen;
    assign out_err     = r_out_err;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed vector table, randomized instructions against a
// reference model, back-pressure, mid-flight reset and counter saturation sequences.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [6:0]  alu_control;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;
    logic [7:0]  illegal_cnt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .alu_control(alu_control),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_err    (out_err),
        .illegal_cnt(illegal_cnt)
    );

    // External ALU stand-in
    always_comb begin
        case (alu_control)
            7'd0:    alu_out = alu_in1 + alu_in2;
            7'd1:    alu_out = alu_in1 - alu_in2;
            7'd2:    alu_out = alu_in1 ^ alu_in2;
            7'd3:    alu_out = alu_in1 | alu_in2;
            7'd4:    alu_out = alu_in1 & alu_in2;
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          legal;
        logic [3:0]  op;
        logic [31:0] in2;
        logic [31:0] result;
        logic [4:0]  rd;
        bit          wen;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int modelCnt = 0;
    logic [3:0]  lastOp  = 4'd0;
    logic [31:0] lastIn1 = 32'd0;
    logic [31:0] lastIn2 = 32'd0;

    task automatic checkVal(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s actual=%h expected=%h", tag, name, act, exp);
        end
    endtask

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    // Reference model built from the instruction-set rules: mnemonic lookup, then plain arithmetic
    function automatic void refModel(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                                     output bit legal, output logic [3:0] op,
                                     output logic [31:0] in2, output logic [31:0] result);
        string mnem;
        int    imm;
        mnem = "";
        imm  = $signed(instr[31:20]);
        in2  = rs2;
        if (instr[6:0] == 7'b0110011) begin
            if      (instr[14:12] == 3'd0 && instr[31:25] == 7'h00) mnem = "add";
            else if (instr[14:12] == 3'd0 && instr[31:25] == 7'h20) mnem = "sub";
            else if (instr[14:12] == 3'd4 && instr[31:25] == 7'h00) mnem = "xor";
            else if (instr[14:12] == 3'd6 && instr[31:25] == 7'h00) mnem = "or";
            else if (instr[14:12] == 3'd7 && instr[31:25] == 7'h00) mnem = "and";
        end else if (instr[6:0] == 7'b0010011) begin
            in2 = imm;
            if      (instr[14:12] == 3'd0) mnem = "add";
            else if (instr[14:12] == 3'd4) mnem = "xor";
            else if (instr[14:12] == 3'd6) mnem = "or";
            else if (instr[14:12] == 3'd7) mnem = "and";
        end
        legal  = (mnem != "");
        op     = 4'd0;
        result = 32'd0;
        if      (mnem == "add") begin op = 4'd0; result = rs1 + in2; end
        else if (mnem == "sub") begin op = 4'd1; result = rs1 - in2; end
        else if (mnem == "xor") begin op = 4'd2; result = rs1 ^ in2; end
        else if (mnem == "or")  begin op = 4'd3; result = rs1 | in2; end
        else if (mnem == "and") begin op = 4'd4; result = rs1 & in2; end
    endfunction

    task automatic checkOutput(input string tag, input bit legal, input logic [31:0] result,
                               input logic [4:0] rd, input bit wen);
        checkVal(tag, "out_valid", out_valid, 1);
        checkVal(tag, "out_result", out_result, result);
        checkVal(tag, "out_rd", out_rd, rd);
        checkVal(tag, "out_wen", out_wen, wen);
        checkVal(tag, "out_err", out_err, !legal);
        checkVal(tag, "illegal_cnt", illegal_cnt, modelCnt);
        checkVal(tag, "alu_control", alu_control, {3'b000, lastOp});
        checkVal(tag, "alu_in1", alu_in1, lastIn1);
        checkVal(tag, "alu_in2", alu_in2, lastIn2);
        checkVal(tag, "in_ready", in_ready, 0);
    endtask

    // One full transaction; holdCycles keeps out_ready low in DONE while a stray in_valid is offered
    task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input bit legal, input logic [3:0] op,
                                 input logic [31:0] in2, input logic [31:0] result,
                                 input logic [4:0] rd, input bit wen, input int holdCycles);
        int lat;
        @(negedge clk);
        checkVal(tag, "in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_instr = instr;
        in_rs1   = rs1;
        in_rs2   = rs2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = $urandom;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        lat = 1;
        if (legal) begin
            lastOp  = op;
            lastIn1 = rs1;
            lastIn2 = in2;
            checkVal(tag, "issue_out_valid", out_valid, 0);
            checkVal(tag, "issue_alu_control", alu_control, {3'b000, op});
            checkVal(tag, "issue_alu_in1", alu_in1, rs1);
            checkVal(tag, "issue_alu_in2", alu_in2, in2);
        end else begin
            modelCnt = (modelCnt >= 255) ? 255 : modelCnt + 1;
        end
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkVal(tag, "latency", lat, legal ? 2 : 1);
        checkOutput(tag, legal, result, rd, wen);
        for (int h = 0; h < holdCycles; h++) begin
            in_valid = 1'b1;
            in_instr = iType(12'h001, 3'b000, 5'd9);
            @(negedge clk);
            checkOutput({tag, "_hold"}, legal, result, rd, wen);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkVal(tag, "release_out_valid", out_valid, 0);
        checkVal(tag, "release_in_ready", in_ready, 1);
        if (holdCycles > 0) begin
            @(negedge clk);
            checkVal(tag, "stray_not_taken_valid", out_valid, 0);
            checkVal(tag, "stray_not_taken_ready", in_ready, 1);
        end
    endtask

    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          mLegal;
        logic [3:0]  mOp;
        logic [31:0] mIn2;
        logic [31:0] mRes;
        logic [31:0] rInstr;
        logic [31:0] rRs1;
        logic [31:0] rRs2;

        vecs[0]  = '{rType(7'h00, 3'd0, 5'd5), 32'd4, 32'd4, 1'b1, 4'd0, 32'd4, 32'd8, 5'd5, 1'b1};
        vecs[1]  = '{rType(7'h20, 3'd0, 5'd3), 32'd8, 32'd4, 1'b1, 4'd1, 32'd4, 32'd4, 5'd3, 1'b1};
        vecs[2]  = '{iType(12'hFFF, 3'd7, 5'd7), 32'h1234, 32'h55, 1'b1, 4'd4, 32'hFFFF_FFFF, 32'h1234, 5'd7, 1'b1};
        vecs[3]  = '{rType(7'h20, 3'd4, 5'd9), 32'h11, 32'h22, 1'b0, 4'd0, 32'd0, 32'd0, 5'd9, 1'b0};
        vecs[4]  = '{iType(12'hFFF, 3'd0, 5'd0), 32'd7, 32'd3, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd6, 5'd0, 1'b0};
        vecs[5]  = '{rType(7'h00, 3'd6, 5'd10), 32'hF0F0, 32'h0F00, 1'b1, 4'd3, 32'h0F00, 32'hFFF0, 5'd10, 1'b1};
        vecs[6]  = '{iType(12'h0FF, 3'd4, 5'd11), 32'h0F0F, 32'h0, 1'b1, 4'd2, 32'h00FF, 32'h0FF0, 5'd11, 1'b1};
        vecs[7]  = '{iType(12'h800, 3'd6, 5'd12), 32'd1, 32'h0, 1'b1, 4'd3, 32'hFFFF_F800, 32'hFFFF_F801, 5'd12, 1'b1};
        vecs[8]  = '{{12'h004, 5'd1, 3'b010, 5'd6, 7'b0000011}, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, 5'd6, 1'b0};
        vecs[9]  = '{rType(7'h00, 3'd1, 5'd13), 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, 5'd13, 1'b0};
        vecs[10] = '{rType(7'h01, 3'd0, 5'd14), 32'd3, 32'd5, 1'b0, 4'd0, 32'd0, 32'd0, 5'd14, 1'b0};
        vecs[11] = '{rType(7'h00, 3'd4, 5'd15), 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 4'd2, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 5'd15, 1'b1};
        vecs[12] = '{rType(7'h00, 3'd7, 5'd16), 32'hFFFF_0000, 32'h1234_5678, 1'b1, 4'd4, 32'h1234_5678, 32'h1234_0000, 5'd16, 1'b1};
        vecs[13] = '{iType(12'h005, 3'd2, 5'd17), 32'd9, 32'd9, 1'b0, 4'd0, 32'd0, 32'd0, 5'd17, 1'b0};
        vecs[14] = '{rType(7'h20, 3'd0, 5'd31), 32'd0, 32'd1, 1'b1, 4'd1, 32'd1, 32'hFFFF_FFFF, 5'd31, 1'b1};

        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        checkVal("reset", "in_ready", in_ready, 1);
        checkVal("reset", "out_valid", out_valid, 0);
        checkVal("reset", "alu_control", alu_control, 0);
        checkVal("reset", "alu_in1", alu_in1, 0);
        checkVal("reset", "alu_in2", alu_in2, 0);
        checkVal("reset", "out_result", out_result, 0);
        checkVal("reset", "out_rd", out_rd, 0);
        checkVal("reset", "out_wen", out_wen, 0);
        checkVal("reset", "out_err", out_err, 0);
        checkVal("reset", "illegal_cnt", illegal_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].legal,
                          vecs[i].op, vecs[i].in2, vecs[i].result, vecs[i].rd, vecs[i].wen, 0);
        end

        for (int i = 0; i < 200; i++) begin
            rInstr = $urandom;
            rRs1   = $urandom;
            rRs2   = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    rInstr[6:0] = 7'b0110011;
                    case ($urandom_range(0, 2))
                        0: rInstr[31:25] = 7'h00;
                        1: rInstr[31:25] = 7'h20;
                        default: ;
                    endcase
                end
                1: rInstr[6:0] = 7'b0010011;
                2: begin
                    rInstr[6:0]   = 7'b0110011;
                    rInstr[31:25] = 7'h00;
                end
                default: ;
            endcase
            refModel(rInstr, rRs1, rRs2, mLegal, mOp, mIn2, mRes);
            applyStimulus($sformatf("rand%0d", i), rInstr, rRs1, rRs2, mLegal, mOp, mIn2, mRes,
                          rInstr[11:7], mLegal && (rInstr[11:7] != 5'd0), 0);
        end

        applyStimulus("backpressure", rType(7'h00, 3'd0, 5'd4), 32'd10, 32'd20, 1'b1, 4'd0, 32'd20, 32'd30,
                      5'd4, 1'b1, 5);

        // Reset while the instruction sits in ISSUE
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = rType(7'h00, 3'd0, 5'd8);
        in_rs1   = 32'd100;
        in_rs2   = 32'd23;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkVal("midreset", "out_valid", out_valid, 0);
        checkVal("midreset", "in_ready", in_ready, 1);
        checkVal("midreset", "alu_control", alu_control, 0);
        checkVal("midreset", "alu_in1", alu_in1, 0);
        checkVal("midreset", "illegal_cnt", illegal_cnt, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        modelCnt = 0;
        lastOp   = 4'd0;
        lastIn1  = 32'd0;
        lastIn2  = 32'd0;
        applyStimulus("postreset_add", rType(7'h00, 3'd0, 5'd8), 32'd100, 32'd23, 1'b1, 4'd0, 32'd23, 32'd123,
                      5'd8, 1'b1, 0);

        for (int i = 0; i < 257; i++) begin
            applyStimulus($sformatf("sat%0d", i), rType(7'h20, 3'd4, 5'd2), 32'd1, 32'd1, 1'b0, 4'd0, 32'd0,
                          32'd0, 5'd2, 1'b0, 0);
        end
        checkVal("saturate", "illegal_cnt_final", illegal_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU control interface. Accepts one decoded-operand instruction at a time, decodes its opcode, funct3 and funct7 fields into the 7-bit ALU control code, and drives the ALU operand and control inputs from registers.
- Captures the ALU result and returns it with the destination register number over a valid/ready handshake.
- Sits between the register-read stage and writeback. The ALU is instantiated outside this block.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction and operands are valid.
- in_ready  output  1  block can accept an instruction.
- in_instr  input  32  RV32 instruction word.
- in_rs1  input  32  rs1 register value.
- in_rs2  input  32  rs2 register value.
- alu_control  output  7  to ALU control; [3:0] selects the operation, [6:4] is always 0.
- alu_in1  output  32  to ALU first operand.
- alu_in2  output  32  to ALU second operand.
- alu_out  input  32  combinational ALU result.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  32  captured result.
- out_rd  output  5  destination register, instr[11:7].
- out_wen  output  1  1 when the instruction is legal and rd != 0.
- out_err  output  1  illegal instruction.
- illegal_cnt  output  CNT_W  saturating count of illegal instructions.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE. All outputs are 0, except in_ready, which is 1 in IDLE.
- ALU op encoding on control[3:0]:
  - 0000 add
  - 0001 sub
  - 0010 xor
  - 0011 or
  - 0100 and
  - Codes 0101-1111 are never driven.
- Decode for opcode 0110011 (R-type):
  - f3=000, f7=0000000 -> add
  - f3=000, f7=0100000 -> sub
  - f3=100, f7=0 -> xor
  - f3=110, f7=0 -> or
  - f3=111, f7=0 -> and
  - alu_in2 = rs2.
- Decode for opcode 0010011 (I-type):
  - f3 000 -> add (addi)
  - f3 100 -> xor (xori)
  - f3 110 -> or (ori)
  - f3 111 -> and (andi)
  - alu_in2 = sign-extended instr[31:20]; f7 is ignored.
- alu_in1 = rs1 in all legal cases.
- Every other opcode, funct3 or funct7 combination is illegal.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: in_ready=1. On in_valid, capture the instruction fields.
    - Legal instruction: load alu_control, alu_in1 and alu_in2 registers, then go to ISSUE.
    - Illegal instruction: out_result=0, out_err=1, out_wen=0, illegal_cnt += 1 (saturates at all-ones), go directly to DONE. ALU registers keep their prior values.
  - ISSUE: in_ready=0. At the clock edge, register out_result<=alu_out, out_err<=0, out_wen<=(rd!=0), then go to DONE.
  - DONE: out_valid=1. out_result, out_rd, out_wen and out_err are held stable while out_ready=0.
    - On out_ready=1: go to IDLE; out_valid drops the next cycle.
- Latency for a legal instruction:
  - Accepted at edge N; ALU inputs valid from N+1.
  - out_valid=1 from edge N+2.
  - Minimum period is 3 cycles per instruction.
- Latency for an illegal instruction: out_valid from N+1.
- in_ready is combinational from state only (state==IDLE). It has no dependency on out_ready; there is no same-cycle bypass.
- alu_control, alu_in1 and alu_in2 hold their values after ISSUE until the next legal accept.
- Arithmetic wraps modulo 2^32 in the ALU; this block performs no width extension beyond the immediate sign-extension.
- Reset asserted mid-ISSUE or mid-DONE aborts the in-flight instruction. The result is lost, and illegal_cnt clears.

Test Plan:
- R-type add, rs1=4, rs2=4, rd=5 -> alu_control=0000000, out_result=8, out_rd=5, out_wen=1, out_valid 2 cycles after accept.
- R-type sub (f7=0100000), rs1=8, rs2=4 -> alu_control=0000001, out_result=4. Then andi with imm=0xFFF, rs1=0x00001234 -> alu_in2=0xFFFFFFFF, alu_control=0000100, out_result=0x00001234.
- Illegal instructions:
  - R-type xor with f7=0100000 -> out_err=1, out_result=0, out_wen=0, illegal_cnt=1, out_valid 1 cycle after accept.
  - 256 further illegal instructions -> illegal_cnt stays at 255.
- addi to rd=0, rs1=7, imm=-1 -> out_result=6, out_wen=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_result are stable, in_ready=0, a new in_valid is ignored. Raising out_ready -> IDLE the next cycle, in_ready=1.
- Assert rst_n=0 while in ISSUE -> out_valid=0, in_ready=1, alu_control=0 immediately, without waiting for a clock edge. The next accepted add completes correctly.
